// File: rtl/dac_abs_writer.sv
// dac_abs_writer: turns the PI loop's signed adjustment into an absolute DAC code.
// After reset or reload it reads the DAC's current code back over SPI and keeps
// it as base. Each loop request then writes sat(base + adj) to the DAC data
// register through the SPI master.
//
// Handshakes (both are level-based request/acknowledge pairs):
//   upstream : adj_arm is raised with adj stable; adj_finished rises one cycle
//              after the SPI write completes and stays high until adj_arm falls.
//   SPI side : dac_ss and dac_arm rise together with to_dac stable; when
//              dac_finished is seen, both fall on that same edge. The next frame
//              waits GAP_CYC idle cycles and for dac_finished to return low.
module dac_abs_writer #(
  parameter int         DAC_WID      = 24,
  parameter int         DAC_DATA_WID = 20,
  parameter logic [3:0] WRITE_CODE   = 4'b0001,
  parameter logic [3:0] READ_CODE    = 4'b1001,
  parameter int         GAP_CYC      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reload,
  input  logic [DAC_DATA_WID-1:0] adj,
  input  logic                    adj_arm,
  output logic                    adj_finished,
  output logic                    base_valid,
  output logic [DAC_DATA_WID-1:0] base,
  output logic [DAC_DATA_WID-1:0] last_code,
  output logic                    sat_flag,
  output logic [DAC_WID-1:0]      to_dac,
  input  logic [DAC_WID-1:0]      from_dac,
  output logic                    dac_ss,
  output logic                    dac_arm,
  input  logic                    dac_finished,
  output logic [2:0]              dbg_state
);

  localparam int W     = DAC_DATA_WID;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_RD_REQ  = 3'd0,
    S_RD_DATA = 3'd1,
    S_IDLE    = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             reload_pend;
  logic [W:0]       sum_q;
  logic [W-1:0]     code_q;
  logic             clamp_hit;
  logic [W-1:0]     clamp_code;
  logic             can_start;
  logic             reload_any;
  logic             unused_from_dac;

  assign dbg_state       = state;
  assign reload_any      = reload | reload_pend;
  // A new frame may start only once the gap has elapsed and the master has
  // released dac_finished from the previous frame.
  assign can_start       = !dac_arm && (gap_cnt == '0) && !dac_finished;
  // Readback frames carry the command echo in the top bits; only data is kept.
  assign unused_from_dac = &{1'b0, from_dac[DAC_WID-1:W]};

  // Saturate the registered W+1 bit sum into the signed W-bit code range.
  always_comb begin
    clamp_hit  = sum_q[W] ^ sum_q[W-1];
    clamp_code = sum_q[W-1:0];
    if (clamp_hit) begin
      if (sum_q[W]) clamp_code = {1'b1, {(W-1){1'b0}}};
      else          clamp_code = {1'b0, {(W-1){1'b1}}};
    end
  end

  // Main sequencer: readback of base, then write cycles, with SPI framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RD_REQ;
      gap_cnt      <= '0;
      reload_pend  <= 1'b0;
      sum_q        <= '0;
      code_q       <= '0;
      adj_finished <= 1'b0;
      base_valid   <= 1'b0;
      base         <= '0;
      last_code    <= '0;
      sat_flag     <= 1'b0;
      to_dac       <= '0;
      dac_ss       <= 1'b0;
      dac_arm      <= 1'b0;
    end else begin
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      // Reload invalidates base at once; the re-read happens when safe.
      if (reload) begin
        base_valid  <= 1'b0;
        reload_pend <= 1'b1;
      end

      case (state)
        S_RD_REQ: begin
          if (!dac_arm) begin
            if (can_start) begin
              to_dac      <= DAC_WID'({READ_CODE, {W{1'b0}}});
              dac_ss      <= 1'b1;
              dac_arm     <= 1'b1;
              reload_pend <= 1'b0;
            end
          end else if (dac_finished) begin
            dac_ss  <= 1'b0;
            dac_arm <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYC - 1);
            state   <= reload_any ? S_RD_REQ : S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (!dac_arm) begin
            if (can_start) begin
              to_dac  <= '0;
              dac_ss  <= 1'b1;
              dac_arm <= 1'b1;
            end
          end else if (dac_finished) begin
            dac_ss  <= 1'b0;
            dac_arm <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYC - 1);
            if (reload_any) begin
              state <= S_RD_REQ;
            end else begin
              base       <= from_dac[W-1:0];
              base_valid <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end

        S_IDLE: begin
          if (reload_any) begin
            reload_pend <= 1'b0;
            state       <= S_RD_REQ;
          end else if (adj_arm && base_valid) begin
            // adj is captured here; later changes do not affect this write.
            sum_q <= {base[W-1], base} + {adj[W-1], adj};
            state <= S_WR;
          end
        end

        S_WR: begin
          if (!dac_arm) begin
            if (can_start) begin
              code_q   <= clamp_code;
              sat_flag <= clamp_hit;
              to_dac   <= DAC_WID'({WRITE_CODE, clamp_code});
              dac_ss   <= 1'b1;
              dac_arm  <= 1'b1;
            end
          end else if (dac_finished) begin
            dac_ss       <= 1'b0;
            dac_arm      <= 1'b0;
            gap_cnt      <= GAP_W'(GAP_CYC - 1);
            last_code    <= code_q;
            adj_finished <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          if (!adj_arm) begin
            adj_finished <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: state <= S_RD_REQ;
      endcase
    end
  end

endmodule
